// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: 2-FF synchronizers, sampled glitch filters, an
// 11-bit frame deframer with parity/stop checks and a mid-frame timeout,
// and a first-word fall-through scan-code FIFO popped by iKeyRead.
// Optional build macro PS2_BREAK_DECODE_EN folds a 0xF0 prefix into a break
// flag carried with the following code (entries grow to 9 bits).
module ps2_keyboard_rx #(
    parameter int SAMPLE_DIV     = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] oKey,
    output logic       oKeyValid,
    input  logic       iKeyRead,
    output logic       oKeyBreak,
    output logic       oParityErr,
    output logic       oFrameErr,
    output logic       oOverflow,
    input  logic       iClearOverflow,
    output logic       oBusy
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FLT_W = $clog2(FILTER_LEN);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
`ifdef PS2_BREAK_DECODE_EN
    localparam int EW    = 9;
`else
    localparam int EW    = 8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } stateT;

    logic [1:0]       clkSyncR, dataSyncR;
    logic [DIV_W-1:0] divCntR;
    logic             sampleTickS;
    logic             clkFiltR, dataFiltR, clkFiltPrevR;
    logic [FLT_W-1:0] clkCntR, dataCntR;
    logic             fallS;
    stateT            stateR, stateNextS;
    logic [2:0]       bitCntR;
    logic [7:0]       shiftR;
    logic             parityR;
    logic [TO_W-1:0]  toCntR;
    logic             timeoutS, frameDoneS, parityOkS, goodFrameS;
    logic             parityErrNextS, frameErrNextS, pushNextS;
    logic             pushR;
    logic [7:0]       pushCodeR;
`ifdef PS2_BREAK_DECODE_EN
    logic             isBreakCodeS, breakArmedR, breakArmedNextS, pushBreakR;
`endif
    logic [EW-1:0]    memR [FIFO_DEPTH];
    logic [AW:0]      wrPtrR, rdPtrR;
    logic             emptyS, fullS, popS, writeS, dropS;
    logic [EW-1:0]    entryS, headS;

    // One filter step: reset the run on a matching sample, flip after FILTER_LEN differing ones.
    function automatic logic [FLT_W:0] filterNext(input logic level, input logic [FLT_W-1:0] cnt,
                                                  input logic sample);
        if (sample == level) begin
            return {level, {FLT_W{1'b0}}};
        end else if (cnt == FLT_W'(FILTER_LEN - 1)) begin
            return {~level, {FLT_W{1'b0}}};
        end else begin
            return {level, cnt + FLT_W'(1)};
        end
    endfunction

    // Two-stage synchronizers for the asynchronous pins, idle high.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkSyncR  <= 2'b11;
            dataSyncR <= 2'b11;
        end else begin
            clkSyncR  <= {clkSyncR[0], PS2_CLK};
            dataSyncR <= {dataSyncR[0], PS2_DATA};
        end
    end

    assign sampleTickS = (divCntR == DIV_W'(SAMPLE_DIV - 1));

    // Sample-tick divider.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            divCntR <= {DIV_W{1'b0}};
        end else if (sampleTickS) begin
            divCntR <= {DIV_W{1'b0}};
        end else begin
            divCntR <= divCntR + DIV_W'(1);
        end
    end

    // Deglitch filters for both lines plus the delayed clock level for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkFiltR     <= 1'b1;
            dataFiltR    <= 1'b1;
            clkCntR      <= {FLT_W{1'b0}};
            dataCntR     <= {FLT_W{1'b0}};
            clkFiltPrevR <= 1'b1;
        end else begin
            clkFiltPrevR <= clkFiltR;
            if (sampleTickS) begin
                {clkFiltR, clkCntR}   <= filterNext(clkFiltR, clkCntR, clkSyncR[1]);
                {dataFiltR, dataCntR} <= filterNext(dataFiltR, dataCntR, dataSyncR[1]);
            end
        end
    end

    assign fallS    = clkFiltPrevR & ~clkFiltR;
    assign timeoutS = (stateR != ST_IDLE) && !fallS && (toCntR == TO_W'(TIMEOUT_CYCLES - 1));
    assign oBusy    = (stateR != ST_IDLE);

    // Deframer state register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateR <= ST_IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Deframer next-state logic; a timeout always abandons the frame.
    always_comb begin
        stateNextS = stateR;
        case (stateR)
            ST_IDLE: begin
                if (fallS && !dataFiltR) stateNextS = ST_DATA;
                else                     stateNextS = ST_IDLE;
            end
            ST_DATA: begin
                if (timeoutS)                         stateNextS = ST_IDLE;
                else if (fallS && bitCntR == 3'd7)    stateNextS = ST_PARITY;
                else                                  stateNextS = ST_DATA;
            end
            ST_PARITY: begin
                if (timeoutS)   stateNextS = ST_IDLE;
                else if (fallS) stateNextS = ST_STOP;
                else            stateNextS = ST_PARITY;
            end
            ST_STOP: begin
                if (timeoutS || fallS) stateNextS = ST_IDLE;
                else                   stateNextS = ST_STOP;
            end
            default: stateNextS = ST_IDLE;
        endcase
    end

    // Frame verdict; parity is judged before the stop bit.
    always_comb begin
        frameDoneS     = (stateR == ST_STOP) && fallS;
        parityOkS      = ^{shiftR, parityR};
        parityErrNextS = frameDoneS && !parityOkS;
        frameErrNextS  = timeoutS || (frameDoneS && parityOkS && !dataFiltR);
        goodFrameS     = frameDoneS && parityOkS && dataFiltR;
`ifdef PS2_BREAK_DECODE_EN
        isBreakCodeS   = (shiftR == 8'hF0);
        pushNextS      = goodFrameS && !isBreakCodeS;
        if (parityErrNextS || frameErrNextS) begin
            breakArmedNextS = 1'b0;
        end else if (goodFrameS) begin
            breakArmedNextS = isBreakCodeS;
        end else begin
            breakArmedNextS = breakArmedR;
        end
`else
        pushNextS      = goodFrameS;
`endif
    end

    // Bit capture on each filtered clock fall.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bitCntR <= 3'd0;
            shiftR  <= 8'h00;
            parityR <= 1'b0;
        end else if (fallS) begin
            case (stateR)
                ST_IDLE:   bitCntR <= 3'd0;
                ST_DATA: begin
                    shiftR  <= {dataFiltR, shiftR[7:1]};
                    bitCntR <= bitCntR + 3'd1;
                end
                ST_PARITY: parityR <= dataFiltR;
                default:   bitCntR <= bitCntR;
            endcase
        end
    end

    // Inactivity counter, held clear while idle and restarted on every fall.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            toCntR <= {TO_W{1'b0}};
        end else if (stateR == ST_IDLE || fallS || timeoutS) begin
            toCntR <= {TO_W{1'b0}};
        end else begin
            toCntR <= toCntR + TO_W'(1);
        end
    end

    // Registered error pulses and the pending push request.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oParityErr  <= 1'b0;
            oFrameErr   <= 1'b0;
            pushR       <= 1'b0;
            pushCodeR   <= 8'h00;
`ifdef PS2_BREAK_DECODE_EN
            pushBreakR  <= 1'b0;
            breakArmedR <= 1'b0;
`endif
        end else begin
            oParityErr  <= parityErrNextS;
            oFrameErr   <= frameErrNextS;
            pushR       <= pushNextS;
            if (goodFrameS) pushCodeR <= shiftR;
`ifdef PS2_BREAK_DECODE_EN
            if (goodFrameS) pushBreakR <= breakArmedR;
            breakArmedR <= breakArmedNextS;
`endif
        end
    end

    assign emptyS = (wrPtrR == rdPtrR);
    assign fullS  = (wrPtrR[AW] != rdPtrR[AW]) && (wrPtrR[AW-1:0] == rdPtrR[AW-1:0]);
    assign popS   = iKeyRead && !emptyS;
    assign writeS = pushR && (!fullS || popS);
    assign dropS  = pushR && fullS && !popS;
`ifdef PS2_BREAK_DECODE_EN
    assign entryS = {pushBreakR, pushCodeR};
`else
    assign entryS = pushCodeR;
`endif
    assign oKeyValid = !emptyS;

    // FIFO storage and pointers; a simultaneous pop frees the slot being written.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtrR <= {(AW + 1){1'b0}};
            rdPtrR <= {(AW + 1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) memR[i] <= {EW{1'b0}};
        end else begin
            if (writeS) begin
                memR[wrPtrR[AW-1:0]] <= entryS;
                wrPtrR <= wrPtrR + (AW + 1)'(1);
            end
            if (popS) rdPtrR <= rdPtrR + (AW + 1)'(1);
        end
    end

    // Sticky overflow; a drop outranks a same-cycle clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oOverflow <= 1'b0;
        end else if (dropS) begin
            oOverflow <= 1'b1;
        end else if (iClearOverflow) begin
            oOverflow <= 1'b0;
        end
    end

    // Head-of-FIFO view, forced to zero when empty.
    always_comb begin
        headS = memR[rdPtrR[AW-1:0]];
        if (emptyS) begin
            oKey      = 8'h00;
            oKeyBreak = 1'b0;
        end else begin
            oKey      = headS[7:0];
`ifdef PS2_BREAK_DECODE_EN
            oKeyBreak = headS[8];
`else
            oKeyBreak = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus randomized
// frames compared against a queue-based model of accepted scan codes.
module tb_ps2_keyboard_rx;

    localparam int SAMPLE_DIV     = 2;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int FIFO_DEPTH     = 4;
    localparam int HALF           = 40;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       iKeyRead = 1'b0;
    logic       iClearOverflow = 1'b0;
    logic [7:0] oKey;
    logic       oKeyValid, oKeyBreak, oParityErr, oFrameErr, oOverflow, oBusy;

    int compared = 0;
    int mismatched = 0;

    logic [8:0] expQ[$];
    bit         expOverflow = 1'b0;
    bit         breakArmed = 1'b0;
    bit         expPe, expFe;

    bit         gotDone;
    logic       v1, v2, pe1, pe2, fe1, fe2;
    logic [8:0] h1, h2;

    ps2_keyboard_rx #(
        .SAMPLE_DIV(SAMPLE_DIV), .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .oKey(oKey), .oKeyValid(oKeyValid), .iKeyRead(iKeyRead), .oKeyBreak(oKeyBreak),
        .oParityErr(oParityErr), .oFrameErr(oFrameErr), .oOverflow(oOverflow),
        .iClearOverflow(iClearOverflow), .oBusy(oBusy)
    );

    always #10 Clock = ~Clock;

    // Parity bit that makes the total count of ones odd.
    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    function automatic logic [8:0] exp_head();
        if (expQ.size() > 0) return expQ[0];
        return 9'h000;
    endfunction

    // Reference model: what one complete frame does to the code queue.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        bit pOk;
        pOk   = (((^d) ^ p) == 1'b1);
        expPe = !pOk;
        expFe = pOk && !s;
        if (pOk && s) begin
`ifdef PS2_BREAK_DECODE_EN
            if (d == 8'hF0) begin
                breakArmed = 1'b1;
            end else begin
                if (expQ.size() < FIFO_DEPTH) expQ.push_back({breakArmed, d});
                else expOverflow = 1'b1;
                breakArmed = 1'b0;
            end
`else
            if (expQ.size() < FIFO_DEPTH) expQ.push_back({1'b0, d});
            else expOverflow = 1'b1;
`endif
        end else begin
            breakArmed = 1'b0;
        end
    endtask

    task automatic model_pop();
        if (expQ.size() > 0) void'(expQ.pop_front());
    endtask

    task automatic send_bit(input logic b);
        PS2_DATA = b;
        repeat (HALF) @(negedge Clock);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge Clock);
        PS2_CLK = 1'b1;
    endtask

    task automatic pop_one();
        iKeyRead = 1'b1;
        @(negedge Clock);
        iKeyRead = 1'b0;
    endtask

    // Drives one frame; captures outputs in the two cycles after the
    // deframer leaves its busy state (the stop-bit fall cycle + 1 and + 2).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit popAtPush);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        PS2_DATA = s;
        repeat (HALF) @(negedge Clock);
        PS2_CLK = 1'b0;
        gotDone = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clock);
            if (!oBusy) begin
                gotDone = 1'b1;
                break;
            end
        end
        compared++;
        if (!gotDone) begin
            mismatched++;
            $display("FAIL frame_end: busy never dropped for code %h", d);
        end
        v1 = oKeyValid; pe1 = oParityErr; fe1 = oFrameErr; h1 = {oKeyBreak, oKey};
        if (popAtPush) iKeyRead = 1'b1;
        @(negedge Clock);
        iKeyRead = 1'b0;
        v2 = oKeyValid; pe2 = oParityErr; fe2 = oFrameErr; h2 = {oKeyBreak, oKey};
        repeat (HALF) @(negedge Clock);
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        repeat (2 * HALF) @(negedge Clock);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge Clock);
        compared++;
        if ({oKey, oKeyValid, oKeyBreak, oParityErr, oFrameErr, oOverflow, oBusy} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h required 0",
                     {oKey, oKeyValid, oKeyBreak, oParityErr, oFrameErr, oOverflow, oBusy});
        end
        Reset = 1'b1;
        repeat (40) @(negedge Clock);
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        model_frame(8'h1C, 1'b0, 1'b1);
        compared++;
        if (v1 !== 1'b0) begin mismatched++; $display("FAIL basic_valid_early: got %b required 0", v1); end
        compared++;
        if (v2 !== 1'b1 || h2 !== 9'h01C) begin
            mismatched++; $display("FAIL basic_head: got valid %b key %h required 1 01c", v2, h2);
        end
        compared++;
        if ({pe1, fe1} !== 2'b00) begin mismatched++; $display("FAIL basic_errs: got %b%b required 00", pe1, fe1); end
        pop_one();
        model_pop();
        compared++;
        if (oKeyValid !== 1'b0 || oKey !== 8'h00) begin
            mismatched++; $display("FAIL basic_after_pop: got valid %b key %h required 0 00", oKeyValid, oKey);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        model_frame(8'h1C, 1'b1, 1'b1);
        compared++;
        if ({pe1, pe2, fe1, fe2} !== {expPe, 1'b0, expFe, 1'b0}) begin
            mismatched++; $display("FAIL parity_pulse: got pe %b%b fe %b%b required pe 10 fe 00", pe1, pe2, fe1, fe2);
        end
        compared++;
        if (v2 !== 1'b0) begin mismatched++; $display("FAIL parity_nopush: got valid %b required 0", v2); end
        send_frame(8'h32, odd_par(8'h32), 1'b1, 1'b0);
        model_frame(8'h32, odd_par(8'h32), 1'b1);
        compared++;
        if (h2 !== exp_head() || v2 !== 1'b1) begin
            mismatched++; $display("FAIL parity_recover: got %h required %h", h2, exp_head());
        end
        pop_one();
        model_pop();
    endtask

    task automatic test_glitch();
        bit seenBusy, seenErr;
        seenBusy = 1'b0; seenErr = 1'b0;
        PS2_DATA = 1'b0;
        PS2_CLK = 1'b0;
        repeat (3 * SAMPLE_DIV) @(negedge Clock);
        PS2_CLK = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clock);
            seenBusy |= oBusy;
            seenErr |= (oParityErr | oFrameErr);
        end
        PS2_DATA = 1'b1;
        compared++;
        if (seenBusy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy: got %b required 0", seenBusy); end
        compared++;
        if (seenErr !== 1'b0 || oKeyValid !== 1'b0) begin
            mismatched++; $display("FAIL glitch_side_effect: got err %b valid %b required 0 0", seenErr, oKeyValid);
        end
        repeat (50) @(negedge Clock);
    endtask

    task automatic test_timeout();
        int  elapsed;
        bit  found;
        logic [7:0] d;
        d = 8'h2A;
        found = 1'b0; elapsed = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        PS2_DATA = 1'b1;
        for (int c = 1; c <= TIMEOUT_CYCLES + 300; c++) begin
            @(negedge Clock);
            if (oFrameErr) begin
                found = 1'b1; elapsed = c;
                break;
            end
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL timeout_seen: got no frame error required pulse"); end
        compared++;
        if (elapsed < TIMEOUT_CYCLES - 50 || elapsed > TIMEOUT_CYCLES) begin
            mismatched++; $display("FAIL timeout_latency: got %0d cycles required %0d..%0d",
                                   elapsed, TIMEOUT_CYCLES - 50, TIMEOUT_CYCLES);
        end
        compared++;
        if (oBusy !== 1'b0 || oKeyValid !== 1'b0 || oParityErr !== 1'b0) begin
            mismatched++; $display("FAIL timeout_state: got busy %b valid %b perr %b required 0 0 0",
                                   oBusy, oKeyValid, oParityErr);
        end
        @(negedge Clock);
        compared++;
        if (oFrameErr !== 1'b0) begin mismatched++; $display("FAIL timeout_pulse_width: got %b required 0", oFrameErr); end
        breakArmed = 1'b0;
        send_frame(d, odd_par(d), 1'b1, 1'b0);
        model_frame(d, odd_par(d), 1'b1);
        compared++;
        if (h2 !== 9'h02A) begin mismatched++; $display("FAIL timeout_recover: got %h required 02a", h2); end
        pop_one();
        model_pop();
    endtask

    task automatic test_overflow();
        for (int d = 1; d <= 5; d++) begin
            send_frame(8'(d), odd_par(8'(d)), 1'b1, 1'b0);
            model_frame(8'(d), odd_par(8'(d)), 1'b1);
            compared++;
            if (oOverflow !== expOverflow) begin
                mismatched++; $display("FAIL overflow_flag_%0d: got %b required %b", d, oOverflow, expOverflow);
            end
        end
        iClearOverflow = 1'b1;
        @(negedge Clock);
        iClearOverflow = 1'b0;
        expOverflow = 1'b0;
        compared++;
        if (oOverflow !== 1'b0) begin mismatched++; $display("FAIL overflow_clear: got %b required 0", oOverflow); end
        // push into a full FIFO while popping: both take effect, no overflow
        send_frame(8'h06, odd_par(8'h06), 1'b1, 1'b1);
        compared++;
        if (h1 !== exp_head()) begin mismatched++; $display("FAIL full_pop_head: got %h required %h", h1, exp_head()); end
        model_pop();
        model_frame(8'h06, odd_par(8'h06), 1'b1);
        compared++;
        if (oOverflow !== 1'b0) begin mismatched++; $display("FAIL full_push_pop_ovf: got %b required 0", oOverflow); end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            compared++;
            if (oKeyValid !== 1'b1 || {oKeyBreak, oKey} !== exp_head()) begin
                mismatched++; $display("FAIL overflow_drain_%0d: got %b %h required 1 %h",
                                       i, oKeyValid, {oKeyBreak, oKey}, exp_head());
            end
            pop_one();
            model_pop();
        end
        compared++;
        if (oKeyValid !== 1'b0) begin mismatched++; $display("FAIL overflow_empty: got %b required 0", oKeyValid); end
    endtask

    task automatic test_midframe_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        compared++;
        if (oBusy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b required 0", oBusy); end
        Reset = 1'b1;
        expQ.delete(); expOverflow = 1'b0; breakArmed = 1'b0;
        repeat (40) @(negedge Clock);
        send_frame(8'h15, odd_par(8'h15), 1'b1, 1'b0);
        model_frame(8'h15, odd_par(8'h15), 1'b1);
        compared++;
        if (h2 !== exp_head() || {pe1, fe1} !== 2'b00) begin
            mismatched++; $display("FAIL midreset_frame: got %h errs %b%b required %h 00", h2, pe1, fe1, exp_head());
        end
        pop_one();
        model_pop();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, s;
        bit         popAt;
        int         sizeBefore;
        logic [8:0] headBefore;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = 8'hF0;
            p = odd_par(d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 6) != 0);
            popAt = ($urandom_range(0, 2) == 0);
            sizeBefore = expQ.size();
            headBefore = exp_head();
            send_frame(d, p, s, popAt);
            if (popAt) model_pop();
            model_frame(d, p, s);
            compared++;
            if (v1 !== (sizeBefore > 0) || h1 !== headBefore) begin
                mismatched++; $display("FAIL rand_%0d_pre: got %b %h required %b %h", n, v1, h1, sizeBefore > 0, headBefore);
            end
            compared++;
            if ({pe1, fe1, pe2, fe2} !== {expPe, expFe, 2'b00}) begin
                mismatched++; $display("FAIL rand_%0d_err: got %b%b%b%b required %b%b00", n, pe1, fe1, pe2, fe2, expPe, expFe);
            end
            compared++;
            if (v2 !== (expQ.size() > 0) || h2 !== exp_head() || oOverflow !== expOverflow) begin
                mismatched++; $display("FAIL rand_%0d_post: got %b %h ovf %b required %b %h ovf %b",
                                       n, v2, h2, oOverflow, expQ.size() > 0, exp_head(), expOverflow);
            end
            repeat ($urandom_range(0, 2)) begin
                compared++;
                if (oKeyValid !== (expQ.size() > 0) || {oKeyBreak, oKey} !== exp_head()) begin
                    mismatched++; $display("FAIL rand_%0d_pop: got %b %h required %b %h",
                                           n, oKeyValid, {oKeyBreak, oKey}, expQ.size() > 0, exp_head());
                end
                pop_one();
                model_pop();
            end
        end
        while (expQ.size() > 0) begin
            pop_one();
            model_pop();
        end
        compared++;
        if (oKeyValid !== 1'b0) begin mismatched++; $display("FAIL rand_drain: got %b required 0", oKeyValid); end
        iClearOverflow = 1'b1;
        @(negedge Clock);
        iClearOverflow = 1'b0;
        expOverflow = 1'b0;
    endtask

`ifdef PS2_BREAK_DECODE_EN
    task automatic test_break();
        breakArmed = 1'b0;
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
        model_frame(8'hF0, odd_par(8'hF0), 1'b1);
        compared++;
        if (v2 !== 1'b0) begin mismatched++; $display("FAIL break_prefix_nopush: got %b required 0", v2); end
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
        model_frame(8'h1C, odd_par(8'h1C), 1'b1);
        compared++;
        if (h2 !== 9'h11C || expQ.size() != 1) begin
            mismatched++; $display("FAIL break_flagged: got %h required 11c", h2);
        end
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
        model_frame(8'h1C, odd_par(8'h1C), 1'b1);
        pop_one();
        model_pop();
        compared++;
        if ({oKeyBreak, oKey} !== 9'h01C) begin
            mismatched++; $display("FAIL break_cleared: got %h required 01c", {oKeyBreak, oKey});
        end
        pop_one();
        model_pop();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_timeout();
        test_overflow();
        test_midframe_reset();
`ifdef PS2_BREAK_DECODE_EN
        test_break();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver that replaces the ad-hoc filter and serial2parallel path feeding the MiniAlu `TEC` instruction. It samples the raw PS2_CLK and PS2_DATA pins, deglitches them, and deframes 11-bit PS/2 frames with parity and stop checking and a mid-frame timeout. Accepted scan codes are buffered in a small FIFO. The ALU pops one code per `TEC` through a valid/read handshake.

Parameters:
SAMPLE_DIV, 2, Clock cycles per filter sample tick (≥1).
FILTER_LEN, 8, consecutive equal samples required before a filtered line changes level (2..16).
TIMEOUT_CYCLES, 50000, Clock cycles without a PS2_CLK falling edge that abort a frame in progress (1 ms at 50 MHz).
FIFO_DEPTH, 4, scan-code entries; power of 2, ≥2.

Ports:
Clock  in  1  system clock (50 MHz).
Reset  in  1  active-low asynchronous reset.
PS2_CLK  in  1  raw keyboard clock pin, asynchronous.
PS2_DATA  in  1  raw keyboard data pin, asynchronous.
oKey  out  8  scan code at the FIFO head; 0 when empty.
oKeyValid  out  1  FIFO not empty.
iKeyRead  in  1  pop the head entry this cycle.
oKeyBreak  out  1  break flag of the head entry (see Optional Feature).
oParityErr  out  1  one-cycle pulse: frame rejected on parity.
oFrameErr  out  1  one-cycle pulse: bad stop bit or timeout.
oOverflow  out  1  sticky: a code was dropped because the FIFO was full.
iClearOverflow  in  1  synchronous clear of oOverflow.
oBusy  out  1  deframer is not in IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While Reset=0: all outputs 0, FIFO empty, FSM in IDLE, filtered lines and synchronizer stages 1, counters 0.
- A Reset assertion mid-frame discards the partial frame; the next frame must start with a fresh start bit.
- Input conditioning: 2-FF synchronizer per pin, then a sample tick every SAMPLE_DIV cycles.
- Each filtered line toggles only after FILTER_LEN consecutive samples that differ from its current level.
- A falling edge of filtered CLK produces a one-cycle strobe `fall`. All bit captures occur on `fall` using filtered DATA.
- FSM states:
  - IDLE: on `fall` with DATA=0 → DATA, bit count 0. On `fall` with DATA=1 → stay in IDLE, no error.
  - DATA: shift DATA in LSB first on each `fall`; after the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: on `fall`, return to IDLE and evaluate the frame:
    - parity OK (ones in data plus parity is odd) and stop=1 → push.
    - parity bad → oParityErr pulse; checked first, so no oFrameErr.
    - parity OK but stop=0 → oFrameErr pulse.
- Timeout: a counter clears on every `fall` and while in IDLE. If it reaches TIMEOUT_CYCLES−1 in any other state, the FSM goes to IDLE and pulses oFrameErr. Nothing is pushed.
- Error pulses are asserted the cycle after the triggering `fall` or timeout.
- FIFO push: the write occurs on the cycle after the stop-bit `fall`. oKeyValid rises on the following cycle. The FIFO is first-word fall-through.
- Pop: iKeyRead=1 with oKeyValid=1 advances the head at the clock edge. iKeyRead on an empty FIFO is ignored.
- Push while full and no pop in the same cycle: the new code is dropped and oOverflow is set. A push and a pop in the same cycle while full both succeed and oOverflow is unchanged.
- iClearOverflow clears oOverflow; if a drop occurs in the same cycle, the set wins.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrapping naturally. Full means the MSBs differ and the remaining bits are equal.

Optional Feature:
Macro PS2_BREAK_DECODE_EN.
- Defined: a valid 0xF0 code is not pushed; it arms a break latch. The next valid code is pushed with its entry break bit = 1, and the latch clears.
- Defined: a parity or frame error clears the latch. FIFO entries are 9 bits, and oKeyBreak shows the head entry's bit.
- Undefined: 0xF0 is pushed as an ordinary code, entries are 8 bits, and oKeyBreak is tied to 0.

Test Plan:
- Frame for 0x1C with parity 0 and stop 1, iKeyRead=0 → oKeyValid=1 with oKey=0x1C 2 cycles after the stop-bit `fall`. Then pulse iKeyRead → oKeyValid=0 and oKey=0.
- Frame for 0x1C with parity 1 → no push, one oParityErr pulse. A following valid 0x32 frame is received correctly.
- A 3-sample low glitch on PS2_CLK with FILTER_LEN=8 → no `fall`, FSM stays IDLE, oBusy=0.
- Start bit plus 4 data bits, then silence for TIMEOUT_CYCLES → oFrameErr pulse and oBusy=0. A following valid 0x2A frame → oKey=0x2A.
- 5 valid frames 0x01..0x05 with no reads, FIFO_DEPTH=4 → entries 0x01..0x04 retained and oOverflow=1. iClearOverflow → oOverflow=0.
- With PS2_BREAK_DECODE_EN: frames 0xF0 then 0x1C → exactly one entry, oKey=0x1C with oKeyBreak=1. A following 0x1C frame → oKeyBreak=0.
